// File: rtl/riscv_mem_port_arbiter.sv
// Shares the core memory port between instruction fetch and the data stage.
// One transaction is in flight at a time. Data has priority, but a streak limit keeps fetch from starving.
module riscv_mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_DM_STREAK = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_if_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_rd_valid,
  output logic [DATA_WIDTH-1:0] o_if_rd_data,
  input  logic                  i_dm_rd_req,
  input  logic                  i_dm_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wr_data,
  input  logic [STRB_WIDTH-1:0] i_dm_wr_strb,
  output logic                  o_dm_rd_valid,
  output logic [DATA_WIDTH-1:0] o_dm_rd_data,
  output logic                  o_dm_wr_ready,
  output logic                  o_mem_rd_ready,
  output logic                  o_mem_wr_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic [STRB_WIDTH-1:0] o_mem_wr_strb,
  input  logic                  i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  input  logic                  i_mem_wr_ready,
  output logic [1:0]            o_grant
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_IF_RD = 2'b01;
  localparam logic [1:0] S_DM_RD = 2'b10;
  localparam logic [1:0] S_DM_WR = 2'b11;

  localparam logic [CNT_WIDTH-1:0] L_MAX_STREAK = CNT_WIDTH'(MAX_DM_STREAK);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_streak;
  logic [CNT_WIDTH-1:0] w_streak_nxt;
  logic [CNT_WIDTH-1:0] w_streak_inc;
  logic [CNT_WIDTH-1:0] w_streak_dm;
  logic                 w_streak_full;

  assign w_streak_full = (r_streak == L_MAX_STREAK);
  assign w_streak_inc  = w_streak_full ? r_streak : r_streak + 1'b1;
  // The streak only counts data grants made while fetch is actually waiting.
  assign w_streak_dm   = i_if_rd_req ? w_streak_inc : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          if (i_if_rd_req && w_streak_full) begin
            w_state_nxt  = S_IF_RD;
            w_streak_nxt = '0;
          end else if (i_dm_wr_req) begin
            w_state_nxt  = S_DM_WR;
            w_streak_nxt = w_streak_dm;
          end else if (i_dm_rd_req) begin
            w_state_nxt  = S_DM_RD;
            w_streak_nxt = w_streak_dm;
          end else begin
            w_state_nxt  = i_if_rd_req ? S_IF_RD : S_IDLE;
            w_streak_nxt = '0;
          end
        end
      end
      S_IF_RD, S_DM_RD: begin
        if (i_mem_rd_valid) w_state_nxt = S_IDLE;
      end
      S_DM_WR: begin
        if (i_mem_wr_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= S_IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Memory-side request is a pure decode of the registered grant.
  assign o_grant        = r_state;
  assign o_mem_rd_ready = (r_state == S_IF_RD) || (r_state == S_DM_RD);
  assign o_mem_wr_valid = (r_state == S_DM_WR);
  assign o_mem_addr     = (r_state == S_IF_RD) ? i_if_addr :
                          (r_state == S_IDLE)  ? '0 : i_dm_addr;
  assign o_mem_wr_data  = o_mem_wr_valid ? i_dm_wr_data : '0;
  assign o_mem_wr_strb  = o_mem_wr_valid ? i_dm_wr_strb : '0;

  assign o_if_rd_valid  = (r_state == S_IF_RD) && i_mem_rd_valid;
  assign o_dm_rd_valid  = (r_state == S_DM_RD) && i_mem_rd_valid;
  assign o_dm_wr_ready  = (r_state == S_DM_WR) && i_mem_wr_ready;
  assign o_if_rd_data   = o_if_rd_valid ? i_mem_rd_data : '0;
  assign o_dm_rd_data   = o_dm_rd_valid ? i_mem_rd_data : '0;

endmodule
